debug_cmd_initiator: RTL and testbench
======================================

# debug_cmd_initiator

Host-side command sequencer that drives the CPU debug harness. It accepts a byte-stream command protocol from the Python UI link. It programs the code ROM byte-by-byte, issues one-cycle run/step commands to the harness, and waits for command completion, program exit or a timeout. Each command returns exactly one status byte on the outgoing stream.

## Interface
Parameters:
- TIMEOUT_CYCLES, 1_000_000: cycles to wait for harness completion before reporting a timeout; minimum 2.
- ADDR_W, 12: code ROM byte-address width.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- rx_data  in  8  command byte from host link
- rx_valid  in  1  rx_data valid
- rx_ready  out  1  byte accepted when rx_valid && rx_ready
- tx_data  out  8  status byte to host link
- tx_valid  out  1  tx_data valid
- tx_ready  in  1  byte consumed when tx_valid && tx_ready
- debug_cmd  out  4  harness command: 0 idle, 1 run, 2 stepi, 3 stepc
- code_rom_data_out  out  8  ROM write data
- code_rom_addr_out  out  ADDR_W  ROM write byte address
- program_rom_mode  out  1  ROM write strobe, high only on write cycles
- reset_code_rom_n  out  1  active-low ROM clear
- command_complete  in  1  one-cycle pulse from harness
- exit_signal  in  1  one-cycle pulse: program finished

## Operation
Host opcodes:
- 0x01 RUN, 0x02 STEPI, 0x03 STEPC: issue the command and wait.
- 0x10 LOAD, followed by addr_hi, addr_lo, len, then data bytes.
  - The address is {addr_hi[3:0], addr_lo}; the upper nibble of addr_hi is ignored.
  - len 0 means 256 data bytes.
- 0x20 CLEAR: clears the code ROM.

Status bytes:
- 0xA1 done
- 0xA2 exit
- 0xA3 timeout
- 0xAE bad opcode

State machine:
- IDLE: rx_ready=1. On an accepted byte, decode the opcode:
  - 0x01–0x03 -> ISSUE
  - 0x10 -> ADDR_HI
  - 0x20 -> CLEAR
  - anything else -> RESP with 0xAE
- ADDR_HI -> ADDR_LO -> LEN -> DATA: each state consumes one byte.
- DATA: each accepted byte produces one write cycle.
  - program_rom_mode=1, with the data and address registered from that byte.
  - The address increments by 1 mod 2^ADDR_W, so 0xFFF wraps to 0x000.
  - After the last byte -> RESP with 0xA1.
- CLEAR: reset_code_rom_n=0 for exactly one cycle -> RESP with 0xA1.
- ISSUE: debug_cmd = command for exactly one cycle, then 0. Clear the timeout counter -> WAIT.
- WAIT: rx_ready=0. Resolve in priority order:
  - exit_signal -> 0xA2
  - command_complete -> 0xA1
  - counter == TIMEOUT_CYCLES-1 -> 0xA3
  - When exit and complete arrive in the same cycle, report 0xA2.
- RESP: tx_valid=1 with tx_data held stable until tx_ready. Then -> IDLE. tx_valid never drops while waiting.
- command_complete and exit_signal pulses are ignored outside WAIT.
- After 0xA2 or 0xA3 the harness is not guaranteed idle. The host must reset the harness before issuing further commands; the initiator does not attempt recovery.
- Reset in any state: return to IDLE and discard any partial command, partial load or pending status.

## Timing
Reset values:
- rx_ready=0 during reset, 1 on the first cycle after.
- tx_valid=0, tx_data=0x00.
- debug_cmd=0, program_rom_mode=0, code_rom_data_out=0, code_rom_addr_out=0.
- reset_code_rom_n=1.

All outputs are registered.

Latency:
- Write strobe: high the cycle after the data byte is accepted.
- debug_cmd: valid the cycle after the opcode is accepted.
- Status byte: tx_valid is asserted the cycle after the terminating event.

Flow control:
- rx_ready=1 in IDLE, ADDR_HI, ADDR_LO, LEN and DATA; 0 in all other states.
- Back-to-back data bytes, one per cycle, are sustained.

Timeout:
- The counter runs from the cycle after ISSUE.
- A completion arriving on the same cycle as terminal count wins over the timeout.

## Structure
- debug_link_pkg holds:
  - host opcode constants
  - status code constants
  - harness debug_cmd encodings (0..3)
  - the FSM state enum typedef
- One sub-module, debug_link_timer: a loadable up-counter with clear, enable and terminal-count flag. Counter width is $clog2(TIMEOUT_CYCLES).

## Test plan
- LOAD 0x10,0x01,0x00,0x04,DE,AD,BE,EF -> 4 consecutive write strobes at addresses 0x100..0x103 with data DE,AD,BE,EF; then tx 0xA1.
- LOAD at 0x0FFE with len 4 -> writes to 0xFFE, 0xFFF, 0x000, 0x001; then 0xA1.
- STEPI, with command_complete pulsed 5 cycles after debug_cmd=2 -> debug_cmd high exactly 1 cycle; then tx 0xA1.
- RUN, with exit_signal and command_complete pulsed in the same cycle -> 0xA2. RUN again with no response and TIMEOUT_CYCLES=16 -> 0xA3 after 16 cycles.
- Opcode 0x7F -> 0xAE with no harness activity. Hold tx_ready=0 for 10 cycles -> tx_valid and tx_data stable throughout.
- Assert reset mid-LOAD after 2 data bytes -> no further strobes, no status byte; the next CLEAR command gives a 1-cycle reset_code_rom_n low, then 0xA1.

Source files
------------

// File: rtl/debug_link_pkg.sv
// Shared constants for the host debug link: opcodes, status codes,
// harness command encodings and the initiator state machine encoding.
package debug_link_pkg;

  localparam logic [7:0] OP_RUN   = 8'h01;
  localparam logic [7:0] OP_STEPI = 8'h02;
  localparam logic [7:0] OP_STEPC = 8'h03;
  localparam logic [7:0] OP_LOAD  = 8'h10;
  localparam logic [7:0] OP_CLEAR = 8'h20;

  localparam logic [7:0] STS_DONE    = 8'hA1;
  localparam logic [7:0] STS_EXIT    = 8'hA2;
  localparam logic [7:0] STS_TIMEOUT = 8'hA3;
  localparam logic [7:0] STS_BAD_OP  = 8'hAE;

  localparam logic [3:0] DBG_IDLE  = 4'd0;
  localparam logic [3:0] DBG_RUN   = 4'd1;
  localparam logic [3:0] DBG_STEPI = 4'd2;
  localparam logic [3:0] DBG_STEPC = 4'd3;

  typedef enum logic [3:0] {
    S_IDLE,
    S_ADDR_HI,
    S_ADDR_LO,
    S_LEN,
    S_DATA,
    S_CLEAR,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  function automatic logic [3:0] op_to_dbg(input logic [7:0] op);
    case (op)
      OP_RUN:   return DBG_RUN;
      OP_STEPI: return DBG_STEPI;
      OP_STEPC: return DBG_STEPC;
      default:  return DBG_IDLE;
    endcase
  endfunction

  // States that take a byte from the host link.
  function automatic logic accepts_rx(input state_t s);
    return (s == S_IDLE) || (s == S_ADDR_HI) || (s == S_ADDR_LO) ||
           (s == S_LEN) || (s == S_DATA);
  endfunction

endpackage

// File: rtl/debug_link_timer.sv
// Loadable up-counter with clear and enable; tc_o flags the last cycle
// of the timeout window (count == TIMEOUT_CYCLES-1).
module debug_link_timer #(
  parameter int TIMEOUT_CYCLES = 1_000_000,
  parameter int CNT_W          = $clog2(TIMEOUT_CYCLES)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             en_i,
  output logic             tc_o
);

  localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (load_i) begin
      count_d = load_val_i;
    end else if (en_i) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tc_o = (count_q == TC_VAL);

endmodule

// File: rtl/debug_cmd_initiator.sv
// Host-side command sequencer for the CPU debug harness: decodes host bytes,
// programs the code ROM, issues run/step commands and returns one status byte.
//
// state   | meaning
// IDLE    | waiting for an opcode byte
// ADDR_HI | LOAD: expecting address high nibble byte
// ADDR_LO | LOAD: expecting address low byte
// LEN     | LOAD: expecting byte count (0 = 256)
// DATA    | LOAD: one ROM write per accepted byte
// CLEAR   | ROM clear pulse active
// ISSUE   | harness command pulse active, timer cleared
// WAIT    | waiting for exit, completion or timeout
// RESP    | status byte offered until consumed
module debug_cmd_initiator
  import debug_link_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1_000_000,
  parameter int ADDR_W         = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic [3:0]        debug_cmd,
  output logic [7:0]        code_rom_data_out,
  output logic [ADDR_W-1:0] code_rom_addr_out,
  output logic              program_rom_mode,
  output logic              reset_code_rom_n,
  input  logic              command_complete,
  input  logic              exit_signal
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

  state_t            state_q, state_d;
  logic              rx_ready_q, rx_ready_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic              tx_valid_q, tx_valid_d;
  logic [3:0]        debug_cmd_q, debug_cmd_d;
  logic [7:0]        rom_data_q, rom_data_d;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic              rom_we_q, rom_we_d;
  logic              rom_clr_n_q, rom_clr_n_d;
  logic [3:0]        addr_hi_q, addr_hi_d;
  logic [ADDR_W-1:0] addr_ptr_q, addr_ptr_d;
  logic [8:0]        remain_q, remain_d;

  logic rx_fire;
  logic tx_fire;
  logic timer_clr;
  logic timer_en;
  logic timer_tc;

  debug_link_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .CNT_W         (CNT_W)
  ) u_timer (
    .clk       (clk),
    .reset     (reset),
    .clear_i   (timer_clr),
    .load_i    (1'b0),
    .load_val_i({CNT_W{1'b0}}),
    .en_i      (timer_en),
    .tc_o      (timer_tc)
  );

  assign rx_fire = rx_valid && rx_ready_q;
  assign tx_fire = tx_valid_q && tx_ready;

  always_comb begin
    state_d     = state_q;
    tx_data_d   = tx_data_q;
    tx_valid_d  = tx_valid_q;
    debug_cmd_d = DBG_IDLE;
    rom_data_d  = rom_data_q;
    rom_addr_d  = rom_addr_q;
    rom_we_d    = 1'b0;
    rom_clr_n_d = 1'b1;
    addr_hi_d   = addr_hi_q;
    addr_ptr_d  = addr_ptr_q;
    remain_d    = remain_q;
    timer_clr   = 1'b0;
    timer_en    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (rx_fire) begin
          case (rx_data)
            OP_RUN, OP_STEPI, OP_STEPC: begin
              state_d     = S_ISSUE;
              debug_cmd_d = op_to_dbg(rx_data);
            end
            OP_LOAD:  state_d = S_ADDR_HI;
            OP_CLEAR: begin
              state_d     = S_CLEAR;
              rom_clr_n_d = 1'b0;
            end
            default: begin
              state_d    = S_RESP;
              tx_valid_d = 1'b1;
              tx_data_d  = STS_BAD_OP;
            end
          endcase
        end
      end
      S_ADDR_HI: begin
        if (rx_fire) begin
          addr_hi_d = rx_data[3:0];
          state_d   = S_ADDR_LO;
        end
      end
      S_ADDR_LO: begin
        if (rx_fire) begin
          addr_ptr_d = ADDR_W'({addr_hi_q, rx_data});
          state_d    = S_LEN;
        end
      end
      S_LEN: begin
        if (rx_fire) begin
          remain_d = (rx_data == 8'h00) ? 9'd256 : {1'b0, rx_data};
          state_d  = S_DATA;
        end
      end
      S_DATA: begin
        if (rx_fire) begin
          rom_we_d   = 1'b1;
          rom_data_d = rx_data;
          rom_addr_d = addr_ptr_q;
          addr_ptr_d = addr_ptr_q + ADDR_W'(1);
          remain_d   = remain_q - 9'd1;
          if (remain_q == 9'd1) begin
            state_d    = S_RESP;
            tx_valid_d = 1'b1;
            tx_data_d  = STS_DONE;
          end
        end
      end
      S_CLEAR: begin
        state_d    = S_RESP;
        tx_valid_d = 1'b1;
        tx_data_d  = STS_DONE;
      end
      S_ISSUE: begin
        timer_clr = 1'b1;
        state_d   = S_WAIT;
      end
      S_WAIT: begin
        // Exit outranks completion, and completion outranks the timeout.
        timer_en = 1'b1;
        if (exit_signal) begin
          state_d    = S_RESP;
          tx_valid_d = 1'b1;
          tx_data_d  = STS_EXIT;
        end else if (command_complete) begin
          state_d    = S_RESP;
          tx_valid_d = 1'b1;
          tx_data_d  = STS_DONE;
        end else if (timer_tc) begin
          state_d    = S_RESP;
          tx_valid_d = 1'b1;
          tx_data_d  = STS_TIMEOUT;
        end
      end
      S_RESP: begin
        if (tx_fire) begin
          tx_valid_d = 1'b0;
          state_d    = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    rx_ready_d = accepts_rx(state_d);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      rx_ready_q  <= 1'b0;
      tx_data_q   <= 8'h00;
      tx_valid_q  <= 1'b0;
      debug_cmd_q <= DBG_IDLE;
      rom_data_q  <= 8'h00;
      rom_addr_q  <= '0;
      rom_we_q    <= 1'b0;
      rom_clr_n_q <= 1'b1;
      addr_hi_q   <= 4'h0;
      addr_ptr_q  <= '0;
      remain_q    <= 9'd0;
    end else begin
      state_q     <= state_d;
      rx_ready_q  <= rx_ready_d;
      tx_data_q   <= tx_data_d;
      tx_valid_q  <= tx_valid_d;
      debug_cmd_q <= debug_cmd_d;
      rom_data_q  <= rom_data_d;
      rom_addr_q  <= rom_addr_d;
      rom_we_q    <= rom_we_d;
      rom_clr_n_q <= rom_clr_n_d;
      addr_hi_q   <= addr_hi_d;
      addr_ptr_q  <= addr_ptr_d;
      remain_q    <= remain_d;
    end
  end

  assign rx_ready          = rx_ready_q;
  assign tx_data           = tx_data_q;
  assign tx_valid          = tx_valid_q;
  assign debug_cmd         = debug_cmd_q;
  assign code_rom_data_out = rom_data_q;
  assign code_rom_addr_out = rom_addr_q;
  assign program_rom_mode  = rom_we_q;
  assign reset_code_rom_n  = rom_clr_n_q;

endmodule

// File: tb/tb_debug_cmd_initiator.sv
// Directed bench for debug_cmd_initiator: drives inputs and checks outputs
// on the falling edge; a monitor logs ROM writes and pulse counts.
module tb_debug_cmd_initiator;

  localparam int TO = 16;
  localparam int AW = 12;

  logic          clk;
  logic          reset;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic          rx_ready;
  logic [7:0]    tx_data;
  logic          tx_valid;
  logic          tx_ready;
  logic [3:0]    debug_cmd;
  logic [7:0]    code_rom_data_out;
  logic [AW-1:0] code_rom_addr_out;
  logic          program_rom_mode;
  logic          reset_code_rom_n;
  logic          command_complete;
  logic          exit_signal;

  debug_cmd_initiator #(.TIMEOUT_CYCLES(TO), .ADDR_W(AW)) dut (
    .clk              (clk),
    .reset            (reset),
    .rx_data          (rx_data),
    .rx_valid         (rx_valid),
    .rx_ready         (rx_ready),
    .tx_data          (tx_data),
    .tx_valid         (tx_valid),
    .tx_ready         (tx_ready),
    .debug_cmd        (debug_cmd),
    .code_rom_data_out(code_rom_data_out),
    .code_rom_addr_out(code_rom_addr_out),
    .program_rom_mode (program_rom_mode),
    .reset_code_rom_n (reset_code_rom_n),
    .command_complete (command_complete),
    .exit_signal      (exit_signal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  int cyc        = 0;
  int cmd_cycles = 0;
  int clr_cycles = 0;
  int txv_cycles = 0;
  logic [AW-1:0] wr_a[$];
  logic [7:0]    wr_d[$];
  int            wr_c[$];
  logic [7:0]    pkt[$];

  always @(posedge clk) begin
    #1;
    cyc++;
    if (program_rom_mode === 1'b1) begin
      wr_a.push_back(code_rom_addr_out);
      wr_d.push_back(code_rom_data_out);
      wr_c.push_back(cyc);
    end
    if (debug_cmd !== 4'd0) cmd_cycles++;
    if (reset_code_rom_n === 1'b0) clr_cycles++;
    if (tx_valid === 1'b1) txv_cycles++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Offers pkt bytes one per cycle (plus optional gap cycles); counts bytes
  // offered while rx_ready was low.
  task automatic send_pkt(input int gap, output int not_ready);
    not_ready = 0;
    foreach (pkt[i]) begin
      if (rx_ready !== 1'b1) not_ready++;
      rx_valid = 1'b1;
      rx_data  = pkt[i];
      @(negedge clk);
      rx_valid = 1'b0;
      if (gap > 0 && i < pkt.size() - 1) repeat (gap) @(negedge clk);
    end
  endtask

  task automatic get_tx(output logic [7:0] b, output int waited, output bit got);
    got = 1'b0; waited = 0; b = 8'h00;
    while (!got && waited < 64) begin
      if (tx_valid === 1'b1) begin
        got = 1'b1;
        b = tx_data;
        tx_ready = 1'b1;
        @(negedge clk);
        tx_ready = 1'b0;
      end else begin
        waited++;
        @(negedge clk);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; tx_ready = 1'b0;
    command_complete = 1'b0; exit_signal = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_checks++; if (rx_ready !== 1'b0) $display("FAIL reset_rx_ready: got %b expected 0", rx_ready); else n_pass++;
    n_checks++; if ({tx_valid, tx_data} !== 9'h000) $display("FAIL reset_tx: got %b/%h expected 0/00", tx_valid, tx_data); else n_pass++;
    n_checks++; if (debug_cmd !== 4'd0) $display("FAIL reset_debug_cmd: got %h expected 0", debug_cmd); else n_pass++;
    n_checks++; if ({program_rom_mode, code_rom_data_out, code_rom_addr_out} !== 21'h0)
      $display("FAIL reset_rom_bus: got %b/%h/%h expected 0/00/000", program_rom_mode, code_rom_data_out, code_rom_addr_out); else n_pass++;
    n_checks++; if (reset_code_rom_n !== 1'b1) $display("FAIL reset_rom_clr_n: got %b expected 1", reset_code_rom_n); else n_pass++;
    reset = 1'b0;
    @(negedge clk);
    n_checks++; if (rx_ready !== 1'b1) $display("FAIL post_reset_rx_ready: got %b expected 1", rx_ready); else n_pass++;
  endtask

  task automatic test_load();
    int nr; logic [7:0] b; int w; bit got;
    logic [AW-1:0] ea[4];
    logic [7:0]    ed[4];
    ea = '{12'h100, 12'h101, 12'h102, 12'h103};
    ed = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    wr_a.delete(); wr_d.delete(); wr_c.delete();
    pkt = '{8'h10, 8'h01, 8'h00, 8'h04, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    send_pkt(0, nr);
    n_checks++; if (nr !== 0) $display("FAIL load_b2b_ready: got %0d stalled bytes expected 0", nr); else n_pass++;
    n_checks++; if (rx_ready !== 1'b0) $display("FAIL load_rx_ready_resp: got %b expected 0", rx_ready); else n_pass++;
    n_checks++; if (wr_a.size() !== 4) $display("FAIL load_strobe_count: got %0d expected 4", wr_a.size()); else n_pass++;
    if (wr_a.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        n_checks++; if (wr_a[i] !== ea[i] || wr_d[i] !== ed[i])
          $display("FAIL load_write%0d: got %h@%h expected %h@%h", i, wr_d[i], wr_a[i], ed[i], ea[i]); else n_pass++;
      end
      n_checks++; if (wr_c[3] - wr_c[0] !== 3) $display("FAIL load_strobe_span: got %0d cycles expected 3", wr_c[3] - wr_c[0]); else n_pass++;
    end
    get_tx(b, w, got);
    n_checks++; if (!got || b !== 8'hA1 || w !== 0) $display("FAIL load_status: got %h (valid=%b wait=%0d) expected a1 wait 0", b, got, w); else n_pass++;
  endtask

  task automatic test_load_wrap();
    int nr; logic [7:0] b; int w; bit got;
    logic [AW-1:0] ea[4];
    logic [7:0]    ed[4];
    ea = '{12'hFFE, 12'hFFF, 12'h000, 12'h001};
    ed = '{8'h11, 8'h22, 8'h33, 8'h44};
    wr_a.delete(); wr_d.delete(); wr_c.delete();
    pkt = '{8'h10, 8'hFF, 8'hFE, 8'h04, 8'h11, 8'h22, 8'h33, 8'h44};
    send_pkt(1, nr);
    n_checks++; if (wr_a.size() !== 4) $display("FAIL wrap_strobe_count: got %0d expected 4", wr_a.size()); else n_pass++;
    if (wr_a.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        n_checks++; if (wr_a[i] !== ea[i] || wr_d[i] !== ed[i])
          $display("FAIL wrap_write%0d: got %h@%h expected %h@%h", i, wr_d[i], wr_a[i], ed[i], ea[i]); else n_pass++;
      end
    end
    get_tx(b, w, got);
    n_checks++; if (!got || b !== 8'hA1) $display("FAIL wrap_status: got %h (valid=%b) expected a1", b, got); else n_pass++;
  endtask

  task automatic test_stepi();
    int nr; int c0; int early; logic [7:0] b; int w; bit got;
    c0 = cmd_cycles; early = 0;
    pkt = '{8'h02};
    send_pkt(0, nr);
    n_checks++; if (debug_cmd !== 4'd2) $display("FAIL stepi_cmd: got %h expected 2", debug_cmd); else n_pass++;
    n_checks++; if (rx_ready !== 1'b0) $display("FAIL stepi_rx_ready: got %b expected 0", rx_ready); else n_pass++;
    repeat (4) begin
      @(negedge clk);
      if (tx_valid !== 1'b0) early++;
    end
    command_complete = 1'b1;
    @(negedge clk);
    command_complete = 1'b0;
    n_checks++; if (cmd_cycles - c0 !== 1) $display("FAIL stepi_cmd_width: got %0d cycles expected 1", cmd_cycles - c0); else n_pass++;
    n_checks++; if (early !== 0) $display("FAIL stepi_early_tx: got %0d cycles expected 0", early); else n_pass++;
    get_tx(b, w, got);
    n_checks++; if (!got || b !== 8'hA1 || w !== 0) $display("FAIL stepi_status: got %h (valid=%b wait=%0d) expected a1 wait 0", b, got, w); else n_pass++;
  endtask

  task automatic test_run_exit();
    int nr; logic [7:0] b; int w; bit got;
    pkt = '{8'h01};
    send_pkt(0, nr);
    n_checks++; if (debug_cmd !== 4'd1) $display("FAIL run_cmd: got %h expected 1", debug_cmd); else n_pass++;
    repeat (2) @(negedge clk);
    exit_signal = 1'b1; command_complete = 1'b1;
    @(negedge clk);
    exit_signal = 1'b0; command_complete = 1'b0;
    get_tx(b, w, got);
    n_checks++; if (!got || b !== 8'hA2 || w !== 0) $display("FAIL run_exit_status: got %h (valid=%b wait=%0d) expected a2 wait 0", b, got, w); else n_pass++;
  endtask

  task automatic test_timeout();
    int nr; int early; logic [7:0] b; int w; bit got;
    early = 0;
    pkt = '{8'h01};
    send_pkt(0, nr);
    // 16 wait cycles follow the issue cycle; status appears on the 17th.
    repeat (16) begin
      @(negedge clk);
      if (tx_valid !== 1'b0) early++;
    end
    n_checks++; if (early !== 0) $display("FAIL timeout_early: got %0d cycles expected 0", early); else n_pass++;
    @(negedge clk);
    n_checks++; if (tx_valid !== 1'b1 || tx_data !== 8'hA3) $display("FAIL timeout_status: got %b/%h expected 1/a3", tx_valid, tx_data); else n_pass++;
    get_tx(b, w, got);
  endtask

  task automatic test_complete_at_tc();
    int nr; logic [7:0] b; int w; bit got;
    pkt = '{8'h03};
    send_pkt(0, nr);
    n_checks++; if (debug_cmd !== 4'd3) $display("FAIL stepc_cmd: got %h expected 3", debug_cmd); else n_pass++;
    repeat (16) @(negedge clk);
    command_complete = 1'b1;
    @(negedge clk);
    command_complete = 1'b0;
    get_tx(b, w, got);
    n_checks++; if (!got || b !== 8'hA1 || w !== 0) $display("FAIL tc_complete_status: got %h (valid=%b wait=%0d) expected a1 wait 0", b, got, w); else n_pass++;
  endtask

  task automatic test_bad_opcode();
    int nr; int c0; int w0; int unstable; logic [7:0] b; int w; bit got;
    command_complete = 1'b1; exit_signal = 1'b1;
    @(negedge clk);
    command_complete = 1'b0; exit_signal = 1'b0;
    @(negedge clk);
    n_checks++; if (tx_valid !== 1'b0) $display("FAIL idle_pulse_ignored: got tx_valid %b expected 0", tx_valid); else n_pass++;
    c0 = cmd_cycles; w0 = wr_a.size(); unstable = 0;
    pkt = '{8'h7F};
    send_pkt(0, nr);
    n_checks++; if (tx_valid !== 1'b1 || tx_data !== 8'hAE) $display("FAIL bad_op_status: got %b/%h expected 1/ae", tx_valid, tx_data); else n_pass++;
    repeat (10) begin
      @(negedge clk);
      if (tx_valid !== 1'b1 || tx_data !== 8'hAE) unstable++;
    end
    n_checks++; if (unstable !== 0) $display("FAIL bad_op_hold: got %0d unstable cycles expected 0", unstable); else n_pass++;
    n_checks++; if (cmd_cycles !== c0 || wr_a.size() !== w0)
      $display("FAIL bad_op_no_activity: got %0d cmd/%0d wr cycles expected 0/0", cmd_cycles - c0, wr_a.size() - w0); else n_pass++;
    get_tx(b, w, got);
    n_checks++; if (tx_valid !== 1'b0 || rx_ready !== 1'b1) $display("FAIL bad_op_release: got tx_valid %b rx_ready %b expected 0/1", tx_valid, rx_ready); else n_pass++;
  endtask

  task automatic test_reset_midload();
    int nr; int t0; int k0; logic [7:0] b; int w; bit got;
    wr_a.delete(); wr_d.delete(); wr_c.delete();
    pkt = '{8'h10, 8'h02, 8'h00, 8'h08, 8'h01, 8'h02};
    send_pkt(0, nr);
    reset = 1'b1;
    t0 = txv_cycles;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    n_checks++; if (wr_a.size() !== 2) $display("FAIL midload_strobes: got %0d expected 2", wr_a.size()); else n_pass++;
    if (wr_a.size() == 2) begin
      n_checks++; if (wr_a[1] !== 12'h201 || wr_d[1] !== 8'h02)
        $display("FAIL midload_write1: got %h@%h expected 02@201", wr_d[1], wr_a[1]); else n_pass++;
    end
    n_checks++; if (txv_cycles !== t0 || rx_ready !== 1'b1)
      $display("FAIL midload_discard: got %0d tx cycles rx_ready %b expected 0/1", txv_cycles - t0, rx_ready); else n_pass++;
    k0 = clr_cycles;
    pkt = '{8'h20};
    send_pkt(0, nr);
    n_checks++; if (reset_code_rom_n !== 1'b0) $display("FAIL clear_pulse_low: got %b expected 0", reset_code_rom_n); else n_pass++;
    @(negedge clk);
    n_checks++; if (reset_code_rom_n !== 1'b1 || clr_cycles - k0 !== 1)
      $display("FAIL clear_pulse_width: got %b/%0d cycles expected 1/1", reset_code_rom_n, clr_cycles - k0); else n_pass++;
    get_tx(b, w, got);
    n_checks++; if (!got || b !== 8'hA1 || w !== 0) $display("FAIL clear_status: got %h (valid=%b wait=%0d) expected a1 wait 0", b, got, w); else n_pass++;
    n_checks++; if (wr_a.size() !== 2) $display("FAIL clear_no_strobe: got %0d expected 2", wr_a.size()); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_load();
    test_load_wrap();
    test_stepi();
    test_run_exit();
    test_timeout();
    test_complete_at_tc();
    test_bad_opcode();
    test_reset_midload();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
